// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB4 memory-backed completer.
//   state_e    : completer FSM states (idle / access phase)
//   wait_cnt_t : wait-state counter, wide enough for 0..15 inserted cycles
//   ofs_f      : number of byte-offset address bits for a given data width
package apb_slave_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } state_e;

  typedef logic [3:0] wait_cnt_t;

  function automatic int unsigned ofs_f(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word storage for apb_slave_mem: DEPTH words of DATA_W bits.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high clear of every word
//   we_i    : per-byte write enables for the word at waddr_i
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : combinational read word index
//   rdata_o : combinational read data
module apb_slave_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we_i[b]) begin
        mem_d[waddr_i][b*8 +: 8] = wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed memory with fixed wait states and byte strobes.
// Optional feature: define APB_SLV_PSLVERR_EN to flag out-of-range accesses on pslverr.
// Ports:
//   pclk, preset : clock and synchronous active-high reset
//   paddr        : byte address (low byte-offset bits ignored)
//   psel/penable : APB select and access-phase strobe
//   pwrite       : 1 = write, 0 = read
//   pwdata/pstrb : write data and byte strobes (strobes ignored on reads)
//   pready       : transfer complete, high in the final access cycle
//   prdata       : read data, non-zero only while pready=1 on a read
//   pslverr      : error response for out-of-range accesses (feature enabled only)
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int unsigned Bytes   = DATA_W / 8;
  localparam int unsigned Ofs     = ofs_f(DATA_W);
  localparam int unsigned IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] Span = (ADDR_W + 1)'(DEPTH * Bytes);
  localparam wait_cnt_t WaitMax   = wait_cnt_t'(WAIT_STATES);

  state_e              state_q, state_d;
  wait_cnt_t           cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [Bytes-1:0]    strb_q, strb_d;
  logic                in_range_q, in_range_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   offset;
  logic                in_range;
  logic [IdxW-1:0]     index;
  logic [DATA_W-1:0]   mem_rdata;
  logic [Bytes-1:0]    mem_we;
  logic                pready_int;

  // Wrapping subtraction folds the lower bound into one compare: an address below
  // BASE_ADDR wraps to a large offset that is never below Span.
  always_comb begin
    offset   = paddr - BASE_ADDR;
    in_range = ({1'b0, offset} < Span);
    index    = IdxW'(offset >> Ofs);
  end

  assign pready_int = (state_q == StAccess) && (cnt_q == WaitMax);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    in_range_d = in_range_q;
    rdata_d    = rdata_q;
    mem_we     = '0;

    unique case (state_q)
      StIdle: begin
        // penable without a preceding setup cycle is ignored
        if (psel && !penable) begin
          state_d    = StAccess;
          cnt_d      = '0;
          idx_d      = index;
          write_d    = pwrite;
          wdata_d    = pwdata;
          strb_d     = pstrb;
          in_range_d = in_range;
          rdata_d    = in_range ? mem_rdata : '0;
        end
      end
      StAccess: begin
        if (!psel) begin
          state_d = StIdle;
          rdata_d = '0;
        end else if (penable) begin
          if (pready_int) begin
            state_d = StIdle;
            rdata_d = '0;
            mem_we  = (write_q && in_range_q) ? strb_q : '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      in_range_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      in_range_q <= in_range_d;
      rdata_q    <= rdata_d;
    end
  end

  apb_slave_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_array (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (index),
    .rdata_o (mem_rdata)
  );

  assign pready = pready_int;
  // rdata_q is already zero for out-of-range reads
  assign prdata = (pready_int && !write_q) ? rdata_q : '0;

`ifdef APB_SLV_PSLVERR_EN
  assign pslverr = pready_int && !in_range_q;
`else
  assign pslverr = 1'b0;
`endif

endmodule
